wm8978_vol_ctrl: RTL and testbench

- Runtime output-volume and mute controller for the WM8978 codec.
- Sits beside the power-up register table, upstream of the I2C driver, and drives the same i2c_exec / i2c_data / i2c_done handshake.
- Takes no action until the power-up configuration reports complete.
- Converts single-cycle up/down/mute key events into a 4-write I2C sequence: headphone L/R (R52/R53), then speaker L/R (R54/R55).

---
 rtl/wm8978_pkg.sv | 26 ++
 rtl/wm8978_vol_ctrl_if.sv | 10 +
 rtl/i2c_wr_seq.sv | 93 +++++++++
 rtl/wm8978_vol_ctrl.sv | 105 ++++++++++
 tb/tb_wm8978_vol_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wm8978_pkg.sv
// Shared definitions for the WM8978 runtime volume/mute controller:
// output-volume register addresses, sequencer state encoding and the
// helper that packs one I2C write word.
package wm8978_pkg;

  localparam logic [6:0] REG_LOUT1 = 7'd52;
  localparam logic [6:0] REG_ROUT1 = 7'd53;
  localparam logic [6:0] REG_LOUT2 = 7'd54;
  localparam logic [6:0] REG_ROUT2 = 7'd55;

  typedef enum logic [1:0] {
    WAIT_CFG  = 2'd0,
    IDLE      = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } seq_state_t;

  // {reg_addr[6:0], vu, zero-cross (kept off), mute, volume[5:0]}
  function automatic logic [15:0] build_vol_word(input logic [6:0] addr,
                                                 input logic       vu,
                                                 input logic       mute,
                                                 input logic [5:0] vol);
    return {addr, vu, 1'b0, mute, vol};
  endfunction

endpackage

// File: rtl/wm8978_vol_ctrl_if.sv
// I2C driver handshake: one write is started by an i2c_exec pulse with
// the word on i2c_data, and acknowledged by an i2c_done pulse.
interface wm8978_vol_ctrl_if;
  logic        i2c_exec;
  logic [15:0] i2c_data;
  logic        i2c_done;

  modport master (output i2c_exec, output i2c_data, input  i2c_done);
  modport slave  (input  i2c_exec, input  i2c_data, output i2c_done);
endinterface

// File: rtl/i2c_wr_seq.sv
// Write-sequence engine: waits for the power-up configuration, then on
// each start request walks a 4-entry word table, issuing one I2C write
// per entry and aborting the sequence if a write is never acknowledged.
module i2c_wr_seq
  import wm8978_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_done_i,
  input  logic             start_i,
  input  logic [3:0][15:0] words_i,
  output logic             accept_o,
  output logic             cfg_seen_o,
  output logic             busy_o,
  output logic             err_o,
  wm8978_vol_ctrl_if.master i2c
);

  seq_state_t  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  assign cfg_seen_o   = (state_q != WAIT_CFG);
  assign busy_o       = (state_q == ISSUE) || (state_q == WAIT_DONE);
  assign err_o        = err_q;
  // The table is built from snapshot registers, so the word stays stable
  // from the exec cycle until the matching done.
  assign i2c.i2c_data = busy_o ? words_i[idx_q] : 16'h0000;

  // Next-state logic: sequencing, acknowledgement and timeout handling.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    accept_o     = 1'b0;
    i2c.i2c_exec = 1'b0;
    case (state_q)
      WAIT_CFG: begin
        if (cfg_done_i) state_d = IDLE;
      end
      IDLE: begin
        if (start_i) begin
          accept_o = 1'b1;
          idx_d    = 2'd0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        i2c.i2c_exec = 1'b1;
        cnt_d        = 16'd0;
        state_d      = WAIT_DONE;
      end
      WAIT_DONE: begin
        // An acknowledgement wins over a timeout landing in the same cycle.
        if (i2c.i2c_done) begin
          if (idx_q == 2'd3) begin
            err_d   = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ISSUE;
          end
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = WAIT_CFG;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_CFG;
      idx_q   <= 2'd0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/wm8978_vol_ctrl.sv
// Runtime output-volume and mute controller for the WM8978. Key events
// update the committed volume/mute immediately; any change raises a
// pending flag that makes the sequencer rewrite R52..R55. Changes made
// while a sequence is in flight coalesce into one follow-up sequence.
module wm8978_vol_ctrl
  import wm8978_pkg::*;
#(
  parameter logic [5:0]  VOL_INIT = 6'd40,
  parameter logic [5:0]  VOL_MAX  = 6'd63,
  parameter logic [5:0]  VOL_STEP = 6'd4,
  parameter logic [15:0] TIMEOUT  = 16'd2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_done,
  input  logic        vol_up,
  input  logic        vol_down,
  input  logic        mute_tgl,
  wm8978_vol_ctrl_if.master i2c,
  output logic [5:0]  volume,
  output logic        muted,
  output logic        busy,
  output logic        err
);

  logic [5:0]       volume_q, volume_d;
  logic             muted_q, muted_d;
  logic             pending_q, pending_d;
  logic [5:0]       snap_vol_q;
  logic             snap_mute_q;
  logic             keys_en, accept, cfg_seen;
  logic [6:0]       vol_sum;
  logic [3:0][15:0] words;

  // 7-bit sum so a step past VOL_MAX saturates instead of wrapping.
  assign vol_sum = {1'b0, volume_q} + {1'b0, VOL_STEP};
  assign keys_en = cfg_done | cfg_seen;
  assign volume  = volume_q;
  assign muted   = muted_q;

  // Key arithmetic and pending flag; a fresh change outranks an accept in
  // the same cycle so it is never lost.
  always_comb begin
    volume_d  = volume_q;
    muted_d   = muted_q;
    pending_d = pending_q;
    if (keys_en) begin
      if (vol_up && !vol_down) begin
        volume_d = (vol_sum > {1'b0, VOL_MAX}) ? VOL_MAX : vol_sum[5:0];
      end else if (vol_down && !vol_up) begin
        volume_d = (volume_q < VOL_STEP) ? 6'd0 : volume_q - VOL_STEP;
      end
      if (mute_tgl) muted_d = ~muted_q;
    end
    if ((volume_d != volume_q) || (muted_d != muted_q)) begin
      pending_d = 1'b1;
    end else if (accept) begin
      pending_d = 1'b0;
    end
  end

  // Committed settings, pending flag and the per-sequence snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      volume_q    <= VOL_INIT;
      muted_q     <= 1'b0;
      pending_q   <= 1'b0;
      snap_vol_q  <= VOL_INIT;
      snap_mute_q <= 1'b0;
    end else begin
      volume_q  <= volume_d;
      muted_q   <= muted_d;
      pending_q <= pending_d;
      if (accept) begin
        snap_vol_q  <= volume_q;
        snap_mute_q <= muted_q;
      end
    end
  end

  // Word table: R52..R55, update bit only on the right-channel writes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      localparam logic [6:0] ADDR = REG_LOUT1 + 7'(gi);
      localparam logic       VU   = ((gi % 2) == 1);
      assign words[gi] = build_vol_word(ADDR, VU, snap_mute_q, snap_vol_q);
    end
  endgenerate

  i2c_wr_seq #(
    .TIMEOUT (TIMEOUT)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .cfg_done_i (cfg_done),
    .start_i    (pending_q),
    .words_i    (words),
    .accept_o   (accept),
    .cfg_seen_o (cfg_seen),
    .busy_o     (busy),
    .err_o      (err),
    .i2c        (i2c)
  );

endmodule

// File: tb/tb_wm8978_vol_ctrl.sv
// Bench for wm8978_vol_ctrl: key stimulus updates a behavioural model of
// volume/mute and pushes the expected I2C words; an I2C-slave process
// acknowledges writes and compares each word as the DUT issues it.
module tb_wm8978_vol_ctrl;

  localparam int VINIT = 40;
  localparam int VMAX  = 63;
  localparam int VSTEP = 4;

  logic       clk = 1'b0;
  logic       rst, cfg_done, vol_up, vol_down, mute_tgl;
  logic [5:0] volume;
  logic       muted, busy, err;

  wm8978_vol_ctrl_if bus();

  wm8978_vol_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_done (cfg_done),
    .vol_up   (vol_up),
    .vol_down (vol_down),
    .mute_tgl (mute_tgl),
    .i2c      (bus),
    .volume   (volume),
    .muted    (muted),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [15:0] exp_q[$];
  int          m_vol = VINIT;
  bit          m_mute = 0, m_busy = 0, m_dirty = 0, m_cfg = 0;
  bit          hold_done = 0, last_done = 0;
  int          wpos = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Four writes R52..R55 carrying the model's current settings.
  function automatic void push_seq();
    for (int i = 0; i < 4; i++)
      exp_q.push_back(16'(((52 + i) << 9) | ((i % 2) << 8) | (int'(m_mute) << 6) | m_vol));
  endfunction

  // One key event: drive for one cycle and apply the key rules to the model.
  task automatic key(input bit up, input bit dn, input bit mt);
    int nv;
    bit nm;
    @(posedge clk); #1;
    vol_up = up; vol_down = dn; mute_tgl = mt;
    if (m_cfg) begin
      nv = m_vol;
      nm = m_mute;
      if (up && !dn)      nv = (m_vol + VSTEP > VMAX) ? VMAX : m_vol + VSTEP;
      else if (dn && !up) nv = (m_vol < VSTEP) ? 0 : m_vol - VSTEP;
      if (mt) nm = !m_mute;
      if (nv != m_vol || nm != m_mute) begin
        m_vol  = nv;
        m_mute = nm;
        if (m_busy) m_dirty = 1;
        else begin m_busy = 1; push_seq(); end
      end
    end
    @(posedge clk); #1;
    vol_up = 0; vol_down = 0; mute_tgl = 0;
  endtask

  task automatic wait_idle(input string tag, input int exp_err);
    int t = 0;
    while ((m_busy || exp_q.size() != 0) && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin
      n_vec++; n_miss++;
      $display("FAIL %s_drain: %0d words still expected, required 0", tag, exp_q.size());
    end
    repeat (8) @(negedge clk);
    check({tag, "_busy"},   busy,   0);
    check({tag, "_volume"}, volume, m_vol);
    check({tag, "_muted"},  muted,  m_mute);
    check({tag, "_err"},    err,    exp_err);
  endtask

  task automatic wait_exec(input string tag);
    int t = 0;
    while (wpos == 0 && t < 50) begin @(negedge clk); t++; end
    if (wpos == 0) begin
      n_vec++; n_miss++;
      $display("FAIL %s_exec: no i2c_exec within 50 cycles, required one", tag);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_exec"},   bus.i2c_exec, 0);
    check({tag, "_data"},   bus.i2c_data, 0);
    check({tag, "_volume"}, volume, VINIT);
    check({tag, "_muted"},  muted, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_err"},    err, 0);
  endtask

  // I2C slave + monitor: compare each issued word, acknowledge after a
  // random latency, and retire the model sequence on its 4th write.
  initial begin
    logic [15:0] w;
    bit          have_w;
    bus.i2c_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.i2c_done = 1'b0;
      if (last_done) begin
        last_done = 0;
        check("busy_fall", busy, 0);
      end
      if (bus.i2c_exec === 1'b1) begin
        have_w = 0;
        w = 16'h0;
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_exec: got word 0x%0h, required no write", bus.i2c_data);
        end else begin
          w = exp_q.pop_front();
          have_w = 1;
          check($sformatf("word%0d", wpos), bus.i2c_data, w);
        end
        wpos++;
        if (!hold_done) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          if (have_w) check("data_hold", bus.i2c_data, w);
          bus.i2c_done = 1'b1;
          if (wpos >= 4) begin
            wpos = 0;
            last_done = 1;
            if (m_dirty) begin m_dirty = 0; push_seq(); end
            else m_busy = 0;
          end
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1; cfg_done = 0; vol_up = 0; vol_down = 0; mute_tgl = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1 rst = 0;

    // Keys before the configuration has finished are discarded.
    key(1, 0, 0);
    repeat (6) @(negedge clk);
    check("precfg_volume", volume, VINIT);

    @(posedge clk); #1 cfg_done = 1; m_cfg = 1;
    repeat (2) @(posedge clk);

    key(1, 0, 0);
    wait_idle("single_up", 0);

    // Events during an in-flight sequence coalesce into one follow-up.
    key(1, 0, 0);
    wait_exec("coalesce");
    key(0, 0, 1);
    key(1, 0, 0);
    key(1, 0, 0);
    key(1, 0, 1);
    wait_idle("coalesce", 0);

    for (int i = 0; i < 7; i++) begin
      key(1, 0, 0);
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    wait_idle("saturate", 0);
    key(1, 0, 0);
    wait_idle("sat_noop", 0);

    for (int i = 0; i < 20; i++) begin
      key(0, 1, 0);
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    wait_idle("floor", 0);
    key(0, 1, 0);
    wait_idle("floor_noop", 0);

    key(1, 1, 0);
    wait_idle("both_keys", 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      key(1, 0, 0);
      else if (r <= 6) key(0, 1, 0);
      else if (r == 7) key(0, 0, 1);
      else if (r == 8) key(1, 0, 1);
      else             key(1, 1, 0);
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end
    wait_idle("random", 0);

    // Withheld acknowledgement: abort with err, then a good sequence clears it.
    hold_done = 1;
    key(0, 0, 1);
    wait_exec("tmo");
    repeat (1990) @(negedge clk);
    check("tmo_busy_before", busy, 1);
    check("tmo_err_before", err, 0);
    for (int t = 0; t < 100 && busy; t++) @(negedge clk);
    check("tmo_busy_after", busy, 0);
    check("tmo_err_after", err, 1);
    exp_q.delete(); m_busy = 0; wpos = 0; hold_done = 0;
    key(0, 0, 1);
    wait_idle("after_tmo", 0);

    // Reset in the middle of a write.
    hold_done = 1;
    key(1, 0, 1);
    wait_exec("rst_mid");
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1; cfg_done = 0;
    m_cfg = 0; exp_q.delete(); m_busy = 0; m_dirty = 0; wpos = 0;
    m_vol = VINIT; m_mute = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset("rst_mid");
    @(posedge clk); #1 rst = 0; hold_done = 0;
    key(1, 0, 0);
    repeat (8) @(negedge clk);
    check("rst_nocfg_volume", volume, VINIT);
    check("rst_nocfg_busy", busy, 0);
    @(posedge clk); #1 cfg_done = 1; m_cfg = 1;
    key(1, 0, 0);
    wait_idle("after_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
